// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
//   Circular instruction queue between the fetch unit and the dual decode
//   stage. Fetch writes one {pc, inst} pair per cycle. Decode consumes up to
//   two pairs per cycle through slots 0 and 1. An empty slot is shown as
//   pc = 0 and inst = 0, so each decoder can derive its own valid bit.
//
//   Optional feature: when the macro IQ_BYPASS_EN is defined, an empty queue
//   forwards the incoming pair straight to slot 0 in the same cycle.
//
// Parameters:
//   DEPTH      number of entries, a power of two and >= 4 (default 8)
// Ports:
//   clk        clock; all state changes on the rising edge
//   reset      synchronous, active-high reset
//   flush      redirect; empties the queue at the next edge
//   in_valid   fetch offers a pair this cycle
//   in_pc      fetched PC
//   in_inst    fetched instruction word
//   in_ready   queue can take a push (depends on registered state only)
//   stall      decode stall; when low, the valid slots are consumed
//   out0_pc    oldest entry PC, 0 when there is none
//   out0_inst  oldest entry instruction, 0 when there is none
//   out1_pc    second-oldest entry PC, 0 when there is none
//   out1_inst  second-oldest entry instruction, 0 when there is none
//   count      number of occupied entries
// -----------------------------------------------------------------------------
module inst_queue #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_inst,
    output logic                       in_ready,
    input  logic                       stall,
    output logic [31:0]                out0_pc,
    output logic [31:0]                out0_inst,
    output logic [31:0]                out1_pc,
    output logic [31:0]                out1_inst,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 64;

    // Storage and pointers
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;

    // Handshake and slot signals
    logic          push;
    logic          push_wr;
    logic [1:0]    pop;
    logic [1:0]    avail;
    logic          bypass_hit;
    logic [AW-1:0] rd_ptr_p1;
    logic [EW-1:0] slot0_entry;
    logic [EW-1:0] slot1_entry;
    logic          slot0_valid;
    logic          slot1_valid;

    // Readiness is a function of the registered occupancy only
    assign in_ready = (count_q != CW'(DEPTH));
    assign count    = count_q;

    // Accepted push; flush always wins
    assign push = in_valid & in_ready & ~flush;

    // Number of slots that hold real entries (0, 1 or 2)
    assign avail = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];

    // Consume only valid slots, and only when decode is not stalled
    assign pop = stall ? 2'd0 : avail;

`ifdef IQ_BYPASS_EN
    // Empty queue forwards the input pair to slot 0 in the same cycle
    assign bypass_hit = (count_q == CW'(0)) & in_valid & ~flush;
    // A bypassed pair that decode takes this cycle is never written
    assign push_wr    = push & ~(bypass_hit & ~stall);
`else
    assign bypass_hit = 1'b0;
    assign push_wr    = push;
`endif

    // Slot presentation from registered pointers and storage
    assign rd_ptr_p1   = AW'(rd_ptr + AW'(1));
    assign slot0_valid = (count_q >= CW'(1));
    assign slot1_valid = (count_q >= CW'(2));
    assign slot0_entry = mem[rd_ptr];
    assign slot1_entry = mem[rd_ptr_p1];

    // Slot 0 output mux: stored entry, bypassed input, or the empty pattern
    always_comb begin
        out0_pc   = 32'h0;
        out0_inst = 32'h0;
        if (slot0_valid) begin
            out0_pc   = slot0_entry[63:32];
            out0_inst = slot0_entry[31:0];
        end else if (bypass_hit) begin
            out0_pc   = in_pc;
            out0_inst = in_inst;
        end
    end

    // Slot 1 output mux: never bypassed
    always_comb begin
        out1_pc   = 32'h0;
        out1_inst = 32'h0;
        if (slot1_valid) begin
            out1_pc   = slot1_entry[63:32];
            out1_inst = slot1_entry[31:0];
        end
    end

    // Entry storage; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (push_wr && !reset) begin
            mem[wr_ptr] <= {in_pc, in_inst};
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            rd_ptr  <= AW'(rd_ptr + AW'(pop));
            wr_ptr  <= AW'(wr_ptr + AW'(push_wr));
            count_q <= CW'(count_q + CW'(push_wr) - CW'(pop));
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_queue
//   Directed self-checking bench for inst_queue with DEPTH = 8. Inputs are
//   driven 1 time unit after each rising edge; outputs are checked before the
//   next rising edge. The bypass section follows IQ_BYPASS_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inst_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [31:0]   in_pc;
    logic [31:0]   in_inst;
    logic          in_ready;
    logic          stall;
    logic [31:0]   out0_pc;
    logic [31:0]   out0_inst;
    logic [31:0]   out1_pc;
    logic [31:0]   out1_inst;
    logic [CW-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .stall     (stall),
        .out0_pc   (out0_pc),
        .out0_inst (out0_inst),
        .out1_pc   (out1_pc),
        .out1_inst (out1_inst),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer a pair whose instruction word is the inverted PC
    task automatic drive(input logic v, input logic [31:0] pc);
        in_valid = v;
        in_pc    = pc;
        in_inst  = ~pc;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        stall = 1'b1;
        drive(1'b1, 32'h0000_1234);

        // Reset held two cycles with in_valid high
        tick();
        tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out0_pc", out0_pc, 32'h0);
        chk("rst_out1_pc", out1_pc, 32'h0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        drive(1'b0, 32'h0);
        tick();
        chk("rst_no_retain", 32'(count), 32'd0);
        chk("rst_no_retain_pc", out0_pc, 32'h0);

        // Fill with stall held high
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'hBFC0_0000 + 32'(4 * i));
            tick();
        end
        chk("fill_count", 32'(count), 32'd8);
        chk("fill_ready", 32'(in_ready), 32'd0);
        chk("fill_out0", out0_pc, 32'hBFC0_0000);
        chk("fill_out1", out1_pc, 32'hBFC0_0004);
        drive(1'b1, 32'hDEAD_BEEF);
        tick();
        chk("ninth_ignored", 32'(count), 32'd8);

        // Drain two per cycle
        drive(1'b0, 32'h0);
        stall = 1'b0;
        #1;
        chk("drain0_out0", out0_pc, 32'hBFC0_0000);
        chk("drain0_out1", out1_pc, 32'hBFC0_0004);
        chk("drain0_inst1", out1_inst, ~32'hBFC0_0004);
        tick();
        chk("drain1_count", 32'(count), 32'd6);
        chk("drain1_out0", out0_pc, 32'hBFC0_0008);
        chk("drain1_out1", out1_pc, 32'hBFC0_000C);
        chk("drain1_inst0", out0_inst, ~32'hBFC0_0008);
        tick();
        chk("drain2_out0", out0_pc, 32'hBFC0_0010);
        tick();
        chk("drain3_out1", out1_pc, 32'hBFC0_001C);
        tick();
        chk("drain_empty_count", 32'(count), 32'd0);
        chk("drain_empty_out0", out0_pc, 32'h0);
        chk("drain_empty_out1", out1_pc, 32'h0);

        // Wrap-around: one push per cycle, one pop per cycle once occupied
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 32'hA000_0000 + 32'(4 * k));
            #1;
            if (k == 0) begin
                chk("wrap_out0_first", out0_pc, 32'h0);
                chk("wrap_count_first", 32'(count), 32'd0);
            end else begin
                chk($sformatf("wrap_out0_%0d", k), out0_pc, 32'hA000_0000 + 32'(4 * (k - 1)));
                chk($sformatf("wrap_count_%0d", k), 32'(count), 32'd1);
            end
            chk($sformatf("wrap_out1_%0d", k), out1_pc, 32'h0);
            tick();
        end
        drive(1'b0, 32'h0);
        #1;
        chk("wrap_last", out0_pc, 32'hA000_002C);
        tick();
        chk("wrap_empty", 32'(count), 32'd0);

        // Single entry with a simultaneous push
        stall = 1'b1;
        drive(1'b1, 32'h0000_00C0);
        tick();
        chk("single_count", 32'(count), 32'd1);
        stall = 1'b0;
        drive(1'b1, 32'h0000_00C4);
        #1;
        chk("single_out0", out0_pc, 32'h0000_00C0);
        chk("single_out1", out1_pc, 32'h0);
        tick();
        chk("single_push_pop_count", 32'(count), 32'd1);
        chk("single_next_out0", out0_pc, 32'h0000_00C4);
        drive(1'b0, 32'h0);
        tick();
        chk("single_empty", 32'(count), 32'd0);

        // Push and pop together at DEPTH-1
        stall = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 32'h0000_0100 + 32'(4 * i));
            tick();
        end
        chk("d1_count", 32'(count), 32'd7);
        chk("d1_ready", 32'(in_ready), 32'd1);
        stall = 1'b0;
        drive(1'b1, 32'h0000_011C);
        tick();
        chk("d1_push_pop_count", 32'(count), 32'd6);
        chk("d1_out0", out0_pc, 32'h0000_0108);
        drive(1'b0, 32'h0);
        tick();
        tick();
        tick();
        chk("d1_drained", 32'(count), 32'd0);

        // Flush overrides a simultaneous push and pop
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h0000_00D0 + 32'(4 * i));
            tick();
        end
        chk("fl_count_pre", 32'(count), 32'd5);
        stall = 1'b0;
        flush = 1'b1;
        drive(1'b1, 32'h0000_00F0);
        #1;
        chk("fl_cycle_out0", out0_pc, 32'h0000_00D0);
        chk("fl_cycle_out1", out1_pc, 32'h0000_00D4);
        tick();
        flush = 1'b0;
        stall = 1'b1;
        drive(1'b0, 32'h0);
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_out0", out0_pc, 32'h0);
        chk("fl_out1", out1_pc, 32'h0);
        tick();
        chk("fl_lost", 32'(count), 32'd0);

        // Reset in the middle of operation
        drive(1'b1, 32'h0000_0200);
        tick();
        tick();
        chk("mid_rst_pre", 32'(count), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 32'h0);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_out0", out0_pc, 32'h0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);

`ifdef IQ_BYPASS_EN
        // Bypass consumed the same cycle
        stall = 1'b0;
        drive(1'b1, 32'hBFC0_0100);
        #1;
        chk("byp_out0", out0_pc, 32'hBFC0_0100);
        chk("byp_inst0", out0_inst, ~32'hBFC0_0100);
        chk("byp_out1", out1_pc, 32'h0);
        tick();
        drive(1'b0, 32'h0);
        chk("byp_count", 32'(count), 32'd0);
        // Bypass shown but stalled, so written
        stall = 1'b1;
        drive(1'b1, 32'hBFC0_0100);
        #1;
        chk("byp_stall_out0", out0_pc, 32'hBFC0_0100);
        tick();
        drive(1'b0, 32'h0);
        chk("byp_stall_count", 32'(count), 32'd1);
        chk("byp_stall_next", out0_pc, 32'hBFC0_0100);
`else
        // Without bypass an empty queue shows nothing the push cycle
        stall = 1'b0;
        drive(1'b1, 32'hBFC0_0100);
        #1;
        chk("nobyp_out0", out0_pc, 32'h0);
        tick();
        drive(1'b0, 32'h0);
        chk("nobyp_count", 32'(count), 32'd1);
        chk("nobyp_next", out0_pc, 32'hBFC0_0100);
        tick();
        chk("nobyp_empty", 32'(count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
